// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: core (port 0) and secondary master (port 1).
// Define DMEM_ARB_RR_EN for round-robin; default is fixed priority with burst limit.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_we,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_we,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    output logic [DATA_W/8-1:0] mem_we,
    input  logic [DATA_W-1:0]   mem_dout
);

    logic       last_q;
    logic       last_d;
    logic [3:0] burst_q;
    logic [3:0] burst_d;
    logic       pick1;
    logic       win1;
    logic       gnt0;
    logic       gnt1;
    logic       rd0;
    logic       rd1;

`ifdef DMEM_ARB_RR_EN
    assign pick1 = ~last_q;
`else
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    assign pick1 = (burst_q == BURST_LIM);
`endif

    always_comb begin
        win1 = 1'b0;
        unique case (1'b1)
            (m0_req & ~m1_req): win1 = 1'b0;
            (~m0_req & m1_req): win1 = 1'b1;
            (m0_req & m1_req):  win1 = pick1;
            default:            win1 = 1'b0;
        endcase
    end

    assign gnt0   = m0_req & ~win1 & ~reset;
    assign gnt1   = m1_req & win1 & ~reset;
    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign rd0    = gnt0 & (m0_we == '0);
    assign rd1    = gnt1 & (m1_we == '0);

    // Idle memory side still presents port 0 so the core's address is live.
    assign mem_addr = gnt1 ? m1_addr : m0_addr;
    assign mem_din  = gnt1 ? m1_wdata : m0_wdata;

    always_comb begin
        mem_we = '0;
        if (gnt1) begin
            mem_we = m1_we;
        end else if (gnt0) begin
            mem_we = m0_we;
        end
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        if (gnt0) begin
            last_d = 1'b0;
        end
        if (gnt1) begin
            last_d = 1'b1;
        end
`ifdef DMEM_ARB_RR_EN
        burst_d = 4'd0;
`else
        if (!m1_req || gnt1) begin
            burst_d = 4'd0;
        end else if (gnt0 && burst_q != 4'hf) begin
            burst_d = burst_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 1'b1;
            burst_q   <= 4'd0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            last_q    <= last_d;
            burst_q   <= burst_d;
            m0_rvalid <= rd0;
            m1_rvalid <= rd1;
            if (rd0) begin
                m0_rdata <= mem_dout;
            end
            if (rd1) begin
                m1_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
// Grant-sequence expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_we;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_we;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:255];
    logic        unused_addr_bits;

    int total = 0;
    int bad = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[9:2]];
    assign unused_addr_bits = ^{mem_addr[31:10], mem_addr[1:0]};

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) begin
                mem[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit exp1 [0:9];
        bit prev1;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
        end
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h14 >> 2] = 32'h12345678;

`ifdef DMEM_ARB_RR_EN
        exp1 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp1 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

        // Reset with both ports requesting writes
        reset    = 1'b1;
        m0_req   = 1'b1;
        m0_addr  = 32'h40;
        m0_wdata = 32'h11111111;
        m0_we    = 4'hf;
        m1_req   = 1'b1;
        m1_addr  = 32'h44;
        m1_wdata = 32'h22222222;
        m1_we    = 4'hf;
        step();
        step();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_mem40", mem[32'h40 >> 2], 32'd0);
        chk("rst_mem44", mem[32'h44 >> 2], 32'd0);

        // Continuous contention from reset: both read
        reset   = 1'b0;
        m0_addr = 32'h10;
        m0_we   = 4'h0;
        m1_addr = 32'h14;
        m1_we   = 4'h0;
        #1;
        prev1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("cont_m0_gnt_%0d", c), 32'(m0_gnt), 32'(!exp1[c]));
            chk($sformatf("cont_m1_gnt_%0d", c), 32'(m1_gnt), 32'(exp1[c]));
            prev1 = exp1[c];
            step();
            chk($sformatf("cont_m0_rv_%0d", c), 32'(m0_rvalid), 32'(!prev1));
            chk($sformatf("cont_m1_rv_%0d", c), 32'(m1_rvalid), 32'(prev1));
            if (prev1) begin
                chk($sformatf("cont_m1_rd_%0d", c), m1_rdata, 32'h12345678);
            end else begin
                chk($sformatf("cont_m0_rd_%0d", c), m0_rdata, 32'hDEADBEEF);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_mem_addr", mem_addr, 32'h10);

        // Reset pulse restores the first-contention winner
        reset = 1'b1;
        step();
        reset  = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        chk("rst2_first_m0", 32'(m0_gnt), 32'd1);
        chk("rst2_first_m1", 32'(m1_gnt), 32'd0);
        step();
        m1_req = 1'b0;
        m0_req = 1'b0;
        step();

        // Single read on port 0
        m0_req  = 1'b1;
        m0_addr = 32'h10;
        m0_we   = 4'h0;
        #1;
        chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rd_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'h10);
        step();
        m0_req = 1'b0;
        chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        step();
        chk("rd_m0_rvalid_pulse", 32'(m0_rvalid), 32'd0);

        // Port 1 partial write then read back
        m1_req   = 1'b1;
        m1_addr  = 32'h20;
        m1_wdata = 32'hA5A5A5A5;
        m1_we    = 4'h3;
        #1;
        chk("wr_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'h3);
        chk("wr_mem_din", mem_din, 32'hA5A5A5A5);
        chk("wr_mem_addr", mem_addr, 32'h20);
        step();
        m1_we = 4'h0;
        #1;
        chk("wr_no_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rb_mem_we", 32'(mem_we), 32'd0);
        chk("rb_m1_gnt", 32'(m1_gnt), 32'd1);
        step();
        m1_req = 1'b0;
        chk("rb_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("rb_m1_rdata", m1_rdata, 32'h0000A5A5);
        chk("rb_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rb_m0_rdata_kept", m0_rdata, 32'hDEADBEEF);

        // Read granted, then reset raised before the capture edge
        m0_req  = 1'b1;
        m0_addr = 32'h14;
        #1;
        chk("mid_m0_gnt", 32'(m0_gnt), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_gnt_in_rst", 32'(m0_gnt), 32'd0);
        step();
        chk("mid_rvalid_drop", 32'(m0_rvalid), 32'd0);
        chk("mid_rdata_clr", m0_rdata, 32'd0);
        reset  = 1'b0;
        m0_req = 1'b0;
        step();
        chk("mid_rvalid_idle", 32'(m0_rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the processor core (port 0) and a secondary master (port 1), such as a program loader or debug/DMA engine. It sits between the core's load/store interface and `data_mem`, in the core top level. Each cycle it selects at most one requester and drives that requester's address, write data and byte-enables onto the memory. It returns read data one cycle later, tagged to the winning port.

## Interface
Parameters:
- `ADDR_W`, 32, address width on both ports and the memory side
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `MAX_BURST`, 4, consecutive port-0 grants allowed while port 1 waits (fixed-priority mode only); legal range 1..15

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req`  in  1  port 0 access request
- `m0_addr`  in  ADDR_W  port 0 byte address
- `m0_wdata`  in  DATA_W  port 0 write data
- `m0_we`  in  DATA_W/8  port 0 byte write enables; all-zero means read
- `m0_gnt`  out  1  port 0 access performed this cycle
- `m0_rvalid`  out  1  port 0 read data valid
- `m0_rdata`  out  DATA_W  port 0 read data
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: identical for port 1
- `mem_addr`  out  ADDR_W  to data memory address
- `mem_din`  out  DATA_W  to data memory write data
- `mem_we`  out  DATA_W/8  to data memory byte write enables
- `mem_dout`  in  DATA_W  from data memory, combinational read of `mem_addr`

## Operation
- Winner selection is combinational from `mX_req` and the registered arbitration state. `mX_gnt = mX_req & winner==X & !reset`.
- Memory outputs:
  - `mem_addr`/`mem_din` carry the winner's fields. With no winner they hold port 0's fields.
  - `mem_we` = winner's `we` when granted, otherwise 0. It is never nonzero while `reset` is high or with no grant.
- Requester rule: keep `req`, `addr`, `wdata` and `we` stable until `gnt` is sampled high. Dropping `req` before grant is legal; the request is simply withdrawn.
- Read capture (`we==0` and granted): `mem_dout` is registered into `mX_rdata`, and `mX_rvalid` pulses for one cycle. A write produces no `rvalid`, and `rdata` keeps its previous value.
- Arbitration state:
  - `last`, 1 bit: the last granted port.
  - `burst_cnt`, 4 bits: consecutive port-0 grants counted while `m1_req` is high.
- Fixed priority (default):
  - Port 0 wins a contention unless `burst_cnt == MAX_BURST`; in that case port 1 wins.
  - `burst_cnt` increments (saturating) on each port-0 grant with `m1_req=1`.
  - It clears on a port-1 grant or on any cycle with `m1_req=0`.
- A lone requester always wins immediately, in either mode.

## Timing
- Grant latency is 0 cycles: a request is granted in the cycle it is presented if it wins. The write commits at the rising edge ending that cycle.
- Read latency is 1 cycle: a read granted in cycle N gives `mX_rvalid=1` and valid `mX_rdata` in cycle N+1. Back-to-back reads sustain one per cycle across either port.
- Reset values: `m0_rvalid=m1_rvalid=0`, `m0_rdata=m1_rdata=0`, `last=1` (port 0 wins the first contention), `burst_cnt=0`. `m0_gnt=m1_gnt=0` and `mem_we=0` while `reset` is high.
- Reset mid-operation: a read granted in the cycle before `reset` rises still asserts `rvalid` only if `reset` is low at that capture edge. Otherwise it is dropped, and the requester must retry.
- Simultaneous read on port 0 with write on port 1 to the same address: only the winner is performed. There is no forwarding.

## Configuration
- `DMEM_ARB_RR_EN` defined: strict round-robin. On contention the port ≠ `last` wins. `last` updates on every grant. `burst_cnt` and `MAX_BURST` are unused (the counter is held at 0).
- `DMEM_ARB_RR_EN` undefined: fixed priority to port 0 with the `MAX_BURST` starvation limit described in Operation.

## Test plan
- Single read: reset, then `m0_req=1`, `m0_addr=0x10`, `m0_we=0`, with the memory holding 0xDEADBEEF at 0x10 → `m0_gnt=1` the same cycle; next cycle `m0_rvalid=1`, `m0_rdata=0xDEADBEEF`; `m1_rvalid` stays 0.
- Write then read: port 1 writes 0xA5A5A5A5 with `we=0x3` to 0x20 over old 0, then reads 0x20 → `mem_we=0x3` in the write cycle only; read returns 0x0000A5A5.
- Fixed-priority starvation limit (macro undefined, `MAX_BURST=4`): both ports request continuously → grants follow 0,0,0,0,1,0,0,0,0,1…; `m1_gnt` is never delayed more than 4 cycles.
- Round-robin (`DMEM_ARB_RR_EN` defined): both ports request continuously from reset → grants alternate 0,1,0,1; each `rvalid` goes to the correct port with the matching data.
- Reset behaviour: assert `reset` with both ports requesting writes → `mem_we=0`, both `gnt=0`, both `rvalid=0`, memory unchanged. After deassertion, the first contention is won by port 0.
